// File: rtl/video_timing_detect.sv
// rtl/video_timing_detect.sv - sink-side video timing measurement, lock detection and pixel coordinates
module video_timing_detect #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter logic [15:0] TIMEOUT     = 16'd8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  input  logic [7:0]  rgb_r,
  input  logic [7:0]  rgb_g,
  input  logic [7:0]  rgb_b,
  output logic [11:0] h_total,
  output logic [11:0] h_sync,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_sync,
  output logic [11:0] v_active,
  output logic        locked,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b
);

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_IDLE, ST_MEAS, ST_TRACK, ST_LOCKED} state_t;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  logic        hs_d1, hs_d2, vs_d1, vs_d2, de_d1, de_d2;
  logic [7:0]  r_d1, g_d1, b_d1;
  logic        hs_rise, vs_rise, de_fall;

  logic [11:0] lclk, hs_cnt, de_cnt;
  logic [11:0] line_total, line_hs, line_de;
  logic        line_has_de;
  logic [11:0] cur_h_total, cur_h_sync, cur_h_active;

  logic [11:0] f_lines, f_sync, f_act;
  logic [11:0] snap_h_total, snap_h_sync, snap_h_active;
  logic [11:0] snap_v_total, snap_v_sync, snap_v_active;
  logic        frame_evt;

  logic [15:0] to_cnt;
  logic        timeout;

  state_t      state, state_nxt;
  logic [3:0]  match_cnt, match_nxt, match_inc;
  logic        ref_load;
  logic [47:0] ref_snap, snap_vec;
  logic        same;

  assign hs_rise = hs_d1 & ~hs_d2;
  assign vs_rise = vs_d1 & ~vs_d2;
  assign de_fall = ~de_d1 & de_d2;

  // Two input register stages; the second stage of de/RGB is the delayed pixel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d1 <= 1'b0; hs_d2 <= 1'b0;
      vs_d1 <= 1'b0; vs_d2 <= 1'b0;
      de_d1 <= 1'b0; de_d2 <= 1'b0;
      r_d1  <= 8'd0; g_d1  <= 8'd0; b_d1  <= 8'd0;
      pix_r <= 8'd0; pix_g <= 8'd0; pix_b <= 8'd0;
    end else begin
      hs_d1 <= hs;    hs_d2 <= hs_d1;
      vs_d1 <= vs;    vs_d2 <= vs_d1;
      de_d1 <= de;    de_d2 <= de_d1;
      r_d1  <= rgb_r; g_d1  <= rgb_g; b_d1  <= rgb_b;
      pix_r <= r_d1;  pix_g <= g_d1;  pix_b <= b_d1;
    end
  end

  assign pix_valid = de_d2;

  // The clock at hs_rise is the first clock of the new line, so counters restart at that clock's value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lclk       <= 12'd0;
      hs_cnt     <= 12'd0;
      de_cnt     <= 12'd0;
      line_total <= 12'd0;
      line_hs    <= 12'd0;
      line_de    <= 12'd0;
    end else if (hs_rise) begin
      line_total <= lclk;
      line_hs    <= hs_cnt;
      if (line_has_de) line_de <= de_cnt;
      lclk       <= 12'd1;
      hs_cnt     <= 12'd1;
      de_cnt     <= {11'd0, de_d1};
    end else begin
      lclk <= sat_inc(lclk);
      if (hs_d1) hs_cnt <= sat_inc(hs_cnt);
      if (de_d1) de_cnt <= sat_inc(de_cnt);
    end
  end

  // A coincident hs_rise latches its line at the same edge, so the snapshot must see those values now
  assign line_has_de  = (de_cnt != 12'd0);
  assign cur_h_total  = hs_rise ? lclk : line_total;
  assign cur_h_sync   = hs_rise ? hs_cnt : line_hs;
  assign cur_h_active = (hs_rise && line_has_de) ? de_cnt : line_de;

  // Frame counters; a coincident hs_rise is counted as line 1 of the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_lines       <= 12'd0;
      f_sync        <= 12'd0;
      f_act         <= 12'd0;
      snap_h_total  <= 12'd0;
      snap_h_sync   <= 12'd0;
      snap_h_active <= 12'd0;
      snap_v_total  <= 12'd0;
      snap_v_sync   <= 12'd0;
      snap_v_active <= 12'd0;
      frame_evt     <= 1'b0;
    end else begin
      frame_evt <= vs_rise;
      if (vs_rise) begin
        snap_h_total  <= cur_h_total;
        snap_h_sync   <= cur_h_sync;
        snap_h_active <= cur_h_active;
        snap_v_total  <= f_lines;
        snap_v_sync   <= f_sync;
        snap_v_active <= f_act;
        f_lines       <= {11'd0, hs_rise};
        f_sync        <= {11'd0, hs_rise};
        f_act         <= {11'd0, hs_rise & line_has_de};
      end else if (hs_rise) begin
        f_lines <= sat_inc(f_lines);
        if (vs_d1)       f_sync <= sat_inc(f_sync);
        if (line_has_de) f_act  <= sat_inc(f_act);
      end
    end
  end

  // Publish the frame snapshot one clock after capture, in step with the lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_total  <= 12'd0;
      h_sync   <= 12'd0;
      h_active <= 12'd0;
      v_total  <= 12'd0;
      v_sync   <= 12'd0;
      v_active <= 12'd0;
    end else if (frame_evt) begin
      h_total  <= snap_h_total;
      h_sync   <= snap_h_sync;
      h_active <= snap_h_active;
      v_total  <= snap_v_total;
      v_sync   <= snap_v_sync;
      v_active <= snap_v_active;
    end
  end

  // Clocks since the last hs_rise; parks at TIMEOUT so the expiry pulse fires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 16'd0;
    end else if (hs_rise) begin
      to_cnt <= 16'd0;
    end else if (to_cnt != TIMEOUT) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout   = !hs_rise && (to_cnt == TIMEOUT - 16'd1);
  assign snap_vec  = {snap_h_total, snap_h_active, snap_v_total, snap_v_active};
  assign same      = (snap_vec == ref_snap);
  assign match_inc = match_cnt + 4'd1;

  // Lock FSM state, match counter and reference snapshot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      match_cnt <= 4'd0;
      ref_snap  <= 48'd0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      if (ref_load) ref_snap <= snap_vec;
    end
  end

  // Lock FSM next state: advances once per frame, loss of hs overrides everything
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    ref_load  = 1'b0;
    if (timeout) begin
      state_nxt = ST_IDLE;
      match_nxt = 4'd0;
    end else if (frame_evt) begin
      case (state)
        ST_IDLE: state_nxt = ST_MEAS;
        ST_MEAS: begin
          ref_load  = 1'b1;
          match_nxt = 4'd0;
          state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          ref_load = 1'b1;
          if (same) begin
            match_nxt = match_inc;
            if (match_inc >= LOCK_N) state_nxt = ST_LOCKED;
          end else begin
            match_nxt = 4'd0;
          end
        end
        ST_LOCKED: begin
          ref_load = 1'b1;
          if (!same) begin
            match_nxt = 4'd0;
            state_nxt = ST_TRACK;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          match_nxt = 4'd0;
        end
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

  // Coordinates track the second register stage so they line up with pix_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x <= 12'd0;
      pix_y <= 12'd0;
    end else begin
      pix_x <= (de_d1 && de_d2) ? pix_x + 12'd1 : 12'd0;
      if (vs_rise)      pix_y <= 12'd0;
      else if (de_fall) pix_y <= pix_y + 12'd1;
    end
  end

endmodule

// File: tb/tb_video_timing_detect.sv
// tb/tb_video_timing_detect.sv - directed bench for video_timing_detect
module tb_video_timing_detect;

  localparam int HS  = 4;
  localparam int HBP = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs, de;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic [11:0] h_total, h_sync, h_active, v_total, v_sync, v_active;
  logic        locked, pix_valid;
  logic [11:0] pix_x, pix_y;
  logic [7:0]  pix_r, pix_g, pix_b;

  int n_checks = 0;
  int n_pass   = 0;

  int   cyc = 0, vs_count = 0, vs_edge_cyc = 0;
  logic vs_q = 1'b0;
  int   lock_vs = -1, lock_dt = -1, unlock_vs = -1, unlock_dt = -1, n_lock_rise = 0;
  logic lk_q = 1'b0;
  int   mx = 0, my = 0, pcnt = 0, last_pcnt = -1, seen_vs = 0;
  logic pv_q = 1'b0;
  int   base;

  video_timing_detect dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .h_total(h_total), .h_sync(h_sync), .h_active(h_active),
    .v_total(v_total), .v_sync(v_sync), .v_active(v_active),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Count clock edges and the edge at which a vs rise is sampled
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (vs && !vs_q) begin
      vs_count    = vs_count + 1;
      vs_edge_cyc = cyc;
    end
    vs_q = vs;
  end

  // Lock-edge timing and pixel-stream scoreboard
  always @(negedge clk) begin
    if (locked && !lk_q) begin
      lock_vs = vs_count; lock_dt = cyc - vs_edge_cyc; n_lock_rise++;
    end
    if (!locked && lk_q) begin
      unlock_vs = vs_count; unlock_dt = cyc - vs_edge_cyc;
    end
    lk_q = locked;
    if (vs_count != seen_vs) begin
      seen_vs = vs_count; my = 0; last_pcnt = pcnt; pcnt = 0;
    end
    if (!rst_n) begin
      mx = 0; my = 0; pv_q = 1'b0;
    end else if (pix_valid) begin
      check("pix_x", pix_x, mx);
      check("pix_y", pix_y, my);
      check("pix_r", pix_r, mx & 255);
      check("pix_g", pix_g, my & 255);
      check("pix_b", pix_b, (mx ^ 8'hA5) & 255);
      mx++; pcnt++; pv_q = 1'b1;
    end else begin
      if (pv_q) begin mx = 0; my++; end
      pv_q = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hs = 0; vs = 0; de = 0; rgb_r = 0; rgb_g = 0; rgb_b = 0;
    end
  endtask

  // One line: hs pulse, back porch, active pixels, front porch; stop_at >= 0 returns mid-active
  task automatic send_line(input int hact, input int hfp, input bit vsl, input bit act,
                           input int y, input int stop_at);
    int xi;
    for (int c = 0; c < HS + HBP + hact + hfp; c++) begin
      @(negedge clk);
      hs = (c < HS);
      vs = vsl;
      if (act && c >= HS + HBP && c < HS + HBP + hact) begin
        xi = c - HS - HBP;
        de = 1; rgb_r = 8'(xi); rgb_g = 8'(y); rgb_b = 8'(xi) ^ 8'hA5;
        if (stop_at >= 0 && xi == stop_at) return;
      end else begin
        de = 0; rgb_r = 0; rgb_g = 0; rgb_b = 0;
      end
    end
  endtask

  task automatic send_frame(input int hact, input int hfp, input int vsy, input int vbp,
                            input int vact, input int vfp);
    for (int l = 0; l < vsy; l++)  send_line(hact, hfp, 1'b1, 1'b0, 0, -1);
    for (int l = 0; l < vbp; l++)  send_line(hact, hfp, 1'b0, 1'b0, 0, -1);
    for (int l = 0; l < vact; l++) send_line(hact, hfp, 1'b0, 1'b1, l, -1);
    for (int l = 0; l < vfp; l++)  send_line(hact, hfp, 1'b0, 1'b0, 0, -1);
  endtask

  // Nominal frame: H 2/4/2 + 8 active = 16, V 1/2/1 + 4 active = 8
  task automatic frame_a();
    send_frame(8, 2, 2, 1, 4, 1);
  endtask

  initial begin
    rst_n = 0; hs = 0; vs = 0; de = 0; rgb_r = 0; rgb_g = 0; rgb_b = 0;
    repeat (3) @(negedge clk);
    check("rst_h_total", h_total, 0);
    check("rst_v_total", v_total, 0);
    check("rst_locked", locked, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    rst_n = 1;
    idle(5);

    repeat (4) frame_a();
    check("lock_vs", lock_vs, 4);
    check("lock_dt", lock_dt, 2);
    check("locked_a", locked, 1);
    check("h_total_a", h_total, 16);
    check("h_sync_a", h_sync, 4);
    check("h_active_a", h_active, 8);
    check("v_total_a", v_total, 8);
    check("v_sync_a", v_sync, 2);
    check("v_active_a", v_active, 4);
    check("pix_per_frame", last_pcnt, 32);

    send_frame(6, 2, 2, 1, 4, 1);
    frame_a();
    check("unlock_vs", unlock_vs, 6);
    check("unlock_dt", unlock_dt, 2);
    check("locked_alt", locked, 0);
    check("h_total_alt", h_total, 14);
    check("h_active_alt", h_active, 6);
    frame_a();
    frame_a();
    check("no_lock_vs8", locked, 0);
    frame_a();
    check("relock_vs", lock_vs, 9);
    check("relock", locked, 1);

    idle(8000);
    check("pre_timeout", locked, 1);
    idle(300);
    check("timeout_locked", locked, 0);
    check("hold_h_total", h_total, 16);
    check("hold_h_active", h_active, 8);
    check("hold_v_total", v_total, 8);
    repeat (3) frame_a();
    check("to_no_lock", locked, 0);
    frame_a();
    check("to_relock_vs", lock_vs, 13);
    check("to_relock", locked, 1);

    send_line(8, 2, 1'b1, 1'b0, 0, -1);
    send_line(8, 2, 1'b1, 1'b0, 0, -1);
    send_line(8, 2, 1'b0, 1'b0, 0, -1);
    send_line(8, 2, 1'b0, 1'b1, 0, 4);
    #2;
    check("pre_rst_valid", pix_valid, 1);
    check("pre_rst_locked", locked, 1);
    rst_n = 0;
    #1;
    check("mid_rst_h_total", h_total, 0);
    check("mid_rst_v_active", v_active, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_pix_valid", pix_valid, 0);
    check("mid_rst_pix_x", pix_x, 0);
    check("mid_rst_pix_r", pix_r, 0);
    idle(2);
    rst_n = 1;
    base = n_lock_rise;
    idle(3);
    repeat (3) frame_a();
    check("post_rst_locked", locked, 0);
    check("post_rst_rises", n_lock_rise, base);

    send_frame(8, 4986, 1, 0, 1, 1);
    send_frame(8, 4986, 1, 0, 1, 1);
    check("sat_h_total", h_total, 4095);
    check("sat_h_sync", h_sync, 4);
    check("sat_h_active", h_active, 8);
    check("sat_v_total", v_total, 3);
    check("sat_v_active", v_active, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
